// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, state size and the inverse S-box table.
`timescale 1ns/1ps
package aes_pkg;

   localparam int AES_STATE_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Entry [0] is the most significant byte; index with {row, col}.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

endpackage

// File: rtl/inv_sub_byte_iter_if.sv
// Valid/ready input and output channels of the iterative InvSubBytes engine.
`timescale 1ns/1ps
interface inv_sub_byte_iter_if;
   import aes_pkg::*;

   logic                           in_valid;
   logic                           in_ready;
   logic [0:8*AES_STATE_BYTES-1]   in_key;
   logic                           out_valid;
   logic                           out_ready;
   logic [0:8*AES_STATE_BYTES-1]   out_key;

   modport master (
      output in_valid, in_key, out_ready,
      input  in_ready, out_valid, out_key
   );

   modport slave (
      input  in_valid, in_key, out_ready,
      output in_ready, out_valid, out_key
   );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box; port order mirrors the encrypt-side sbox.
`timescale 1ns/1ps
module inv_sbox
   import aes_pkg::*;
(
   input  logic [3:0] row_i,
   input  logic [3:0] col_i,
   output logic [7:0] byte_o
);

   assign byte_o = INV_SBOX[{row_i, col_i}];

endmodule

// File: rtl/inv_sub_byte_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per clock
// through a shared bank of inverse S-boxes, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module inv_sub_byte_iter
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   inv_sub_byte_iter_if.slave  bus,
   output logic                busy
);

   localparam int N     = AES_STATE_BYTES / BYTES_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("inv_sub_byte_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   state_e                         state_q;
   logic [CNT_W-1:0]               cnt_q;
   logic [0:8*AES_STATE_BYTES-1]   work_q;
   logic [0:8*AES_STATE_BYTES-1]   work_d;
   logic                           out_valid_q;
   logic                           in_ready_q;
   logic                           busy_q;

   logic [3:0]                     grp_idx [BYTES_PER_CYCLE];
   logic [7:0]                     sb_in   [BYTES_PER_CYCLE];
   logic [7:0]                     sb_out  [BYTES_PER_CYCLE];

   // Each S-box lane g serves byte cnt*BPC+g of the working register.
   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      assign grp_idx[g] = 4'(32'(cnt_q) * BYTES_PER_CYCLE + g);
      assign sb_in[g]   = work_q[{grp_idx[g], 3'b000} +: 8];

      inv_sbox u_inv_sbox (
         .row_i  (sb_in[g][7:4]),
         .col_i  (sb_in[g][3:0]),
         .byte_o (sb_out[g])
      );
   end

   always_comb begin
      work_d = work_q;
      case (state_q)
         IDLE: if (bus.in_valid) work_d = bus.in_key;
         RUN: begin
            for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
               work_d[{grp_idx[g], 3'b000} +: 8] = sb_out[g];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         work_q <= work_d;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  state_q    <= RUN;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               if (cnt_q == LAST) begin
                  state_q     <= DONE;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               // in_ready reopens only once the result has been taken.
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_key   = work_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_inv_sub_byte_iter.sv
// Directed and round-trip bench for inv_sub_byte_iter, plus a BYTES_PER_CYCLE sweep.
`timescale 1ns/1ps
module tb_inv_sub_byte_iter;

   localparam logic [0:127] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [0:127] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sw_rst_n = 1'b0;
   logic busy;
   int   n_chk = 0;
   int   n_bad = 0;
   logic [7:0] fsb [256];

   always #5 clk = ~clk;

   inv_sub_byte_iter_if bus ();

   inv_sub_byte_iter #(.BYTES_PER_CYCLE(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [0:127] sub_state(input logic [0:127] k);
      logic [0:127] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = fsb[k[8*i +: 8]];
      return r;
   endfunction

   // Forward S-box built from GF(2^8) inversion plus the affine map.
   task automatic build_fsb();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         fsb[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!bus.in_ready && t < 50) begin tick(); t++; end
   endtask

   task automatic wait_valid(output int t);
      t = 0;
      while (!bus.out_valid && t < 50) begin tick(); t++; end
   endtask

   task automatic run_vec(input string tag, input logic [0:127] key, input logic [0:127] exp);
      int t;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_key   = key;
      tick();
      bus.in_valid = 1'b0;
      bus.in_key   = ~key;
      wait_valid(t);
      chk({tag, "_lat"}, 128'(t), 128'(4));
      chk(tag, bus.out_key, exp);
      if (bus.out_ready) tick();
   endtask

   // Sweep copies run the FIPS vector once each, on their own reset.
   for (genvar s = 0; s < 4; s++) begin : g_sw
      localparam int BPC = (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 8 : 16;
      localparam int NN  = 16 / BPC;
      inv_sub_byte_iter_if sif ();
      logic sbusy;
      logic done_f = 1'b0;

      inv_sub_byte_iter #(.BYTES_PER_CYCLE(BPC)) u_sw (
         .clk   (clk),
         .rst_n (sw_rst_n),
         .bus   (sif),
         .busy  (sbusy)
      );

      initial begin
         int t;
         sif.in_valid  = 1'b0;
         sif.in_key    = '0;
         sif.out_ready = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         sif.in_valid = 1'b1;
         sif.in_key   = FIPS_IN;
         @(posedge clk); #1;
         sif.in_valid = 1'b0;
         sif.in_key   = '0;
         t = 0;
         while (!sif.out_valid && t < 50) begin @(posedge clk); #1; t++; end
         chk($sformatf("sweep%0d_lat", BPC), 128'(t), 128'(NN));
         chk($sformatf("sweep%0d_key", BPC), sif.out_key, FIPS_OUT);
         @(posedge clk); #1;
         chk($sformatf("sweep%0d_busy", BPC), 128'(sbusy), 128'(0));
         done_f = 1'b1;
      end
   end

   initial begin
      int t;
      logic [0:127] orig;
      build_fsb();
      bus.in_valid  = 1'b0;
      bus.in_key    = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_ovalid", 128'(bus.out_valid), 128'(0));
      chk("rst_okey", bus.out_key, 128'h0);
      chk("rst_busy", 128'(busy), 128'(0));
      rst_n    = 1'b1;
      sw_rst_n = 1'b1;
      tick();
      chk("rst_inrdy", 128'(bus.in_ready), 128'(1));
      chk("rst_busy2", 128'(busy), 128'(0));

      run_vec("fips", FIPS_IN, FIPS_OUT);
      run_vec("b63", {16{8'h63}}, {16{8'h00}});
      run_vec("b16", {16{8'h16}}, {16{8'hff}});
      run_vec("b7ced", {8{16'h7ced}}, {8{16'h0153}});

      // Backpressure with a competing input during the stall.
      bus.out_ready = 1'b0;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_key   = FIPS_IN;
      tick();
      bus.in_valid = 1'b0;
      wait_valid(t);
      chk("bp_lat", 128'(t), 128'(4));
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_key   = {16{8'h63}};
         chk("bp_key", bus.out_key, FIPS_OUT);
         chk("bp_inrdy", 128'(bus.in_ready), 128'(0));
         chk("bp_ovalid", 128'(bus.out_valid), 128'(1));
         tick();
      end
      chk("bp_key_end", bus.out_key, FIPS_OUT);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_rel_ovalid", 128'(bus.out_valid), 128'(0));
      chk("bp_rel_inrdy", 128'(bus.in_ready), 128'(1));
      tick();
      chk("bp_acc_inrdy", 128'(bus.in_ready), 128'(0));
      chk("bp_acc_busy", 128'(busy), 128'(1));
      bus.in_valid = 1'b0;
      wait_valid(t);
      chk("bp2_lat", 128'(t), 128'(4));
      chk("bp2_key", bus.out_key, {16{8'h00}});
      tick();

      // Reset while RUN is part way through the state.
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_key   = FIPS_IN;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mr_inrdy", 128'(bus.in_ready), 128'(1));
      chk("mr_ovalid", 128'(bus.out_valid), 128'(0));
      chk("mr_okey", bus.out_key, 128'h0);
      chk("mr_busy", 128'(busy), 128'(0));
      run_vec("mr_fips", FIPS_IN, FIPS_OUT);

      for (int i = 0; i < 1000; i++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         run_vec("rt", sub_state(orig), orig);
      end

      t = 0;
      while (!(g_sw[0].done_f && g_sw[1].done_f && g_sw[2].done_f && g_sw[3].done_f) && t < 200) begin
         tick();
         t++;
      end
      chk("sweep_done", 128'(t < 200), 128'(1));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
